bpm_tempo_core: RTL

Consumer end of the button pulse interface: takes the single-cycle, already-debounced pulses (soft reset, +1, +5, −1, −5 BPM) and owns the metronome tempo. Holds a saturating BPM register and drives a phase-accumulator beat generator. Emits a one-cycle beat strobe, a downbeat strobe and the beat index within the bar, for the tone and display logic.

---
 rtl/metronome_pkg.sv | 23 ++
 rtl/beat_phase_acc.sv | 64 ++++++
 rtl/bpm_tempo_core.sv | 93 +++++++++
 3 files changed

// File: rtl/metronome_pkg.sv
// Shared widths, button delta weights and tempo parameter legality check
// for the metronome tempo core.
package metronome_pkg;

   localparam int BPM_W      = 9;
   localparam int BEAT_IDX_W = 3;

   localparam logic signed [10:0] DELTA_P1 = 11'sd1;
   localparam logic signed [10:0] DELTA_P5 = 11'sd5;
   localparam logic signed [10:0] DELTA_M1 = -11'sd1;
   localparam logic signed [10:0] DELTA_M5 = -11'sd5;

   // BPM_MAX below half of TICKS guarantees at most one beat per two cycles.
   function automatic bit params_ok(input int bpm_min, input int bpm_def,
                                    input int bpm_max, input int beats,
                                    input longint ticks);
      return (bpm_min <= bpm_def) && (bpm_def <= bpm_max) &&
             (longint'(bpm_max) < (longint'(1) << BPM_W)) &&
             (longint'(bpm_max) < ticks / 2) &&
             (beats >= 2) && (beats <= 8);
   endfunction

endpackage

// File: rtl/beat_phase_acc.sv
// Phase accumulator beat generator: adds the tempo every cycle and emits a
// beat each time the phase wraps past TICKS, tracking the index within the bar.
module beat_phase_acc
   import metronome_pkg::*;
#(
   parameter longint TICKS         = 64'd3_000_000_000,
   parameter int     ACC_W         = 32,
   parameter int     BPM_WIDTH     = 9,
   parameter int     BEATS_PER_BAR = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [BPM_WIDTH-1:0]  i_bpm,
   input  logic                  i_clear,
   output logic                  o_beat,
   output logic                  o_downbeat,
   output logic [BEAT_IDX_W-1:0] o_idx
);

   localparam logic [ACC_W-1:0]      TICKS_V  = ACC_W'(TICKS);
   localparam logic [BEAT_IDX_W-1:0] IDX_LAST = BEAT_IDX_W'(BEATS_PER_BAR - 1);

   logic [ACC_W-1:0]      r_acc;
   logic [BEAT_IDX_W-1:0] r_idx;
   logic                  r_beat;
   logic                  r_downbeat;

   logic [ACC_W-1:0]      w_sum;
   logic                  w_wrap;
   logic [BEAT_IDX_W-1:0] w_idx_next;

   // acc stays below TICKS, so acc + BPM_MAX always fits in ACC_W bits
   assign w_sum      = r_acc + {{(ACC_W-BPM_WIDTH){1'b0}}, i_bpm};
   assign w_wrap     = (w_sum >= TICKS_V);
   assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + BEAT_IDX_W'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc      <= '0;
         r_idx      <= IDX_LAST;
         r_beat     <= 1'b0;
         r_downbeat <= 1'b0;
      end else if (i_clear) begin
         r_acc      <= '0;
         r_idx      <= IDX_LAST;
         r_beat     <= 1'b0;
         r_downbeat <= 1'b0;
      end else begin
         r_beat     <= w_wrap;
         r_downbeat <= w_wrap && (w_idx_next == '0);
         if (w_wrap) begin
            r_acc <= w_sum - TICKS_V;
            r_idx <= w_idx_next;
         end else begin
            r_acc <= w_sum;
         end
      end
   end

   assign o_beat     = r_beat;
   assign o_downbeat = r_downbeat;
   assign o_idx      = r_idx;

endmodule

// File: rtl/bpm_tempo_core.sv
// Metronome tempo owner: sums button deltas into a saturating BPM register
// and drives the beat phase accumulator from it.
module bpm_tempo_core
   import metronome_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int BPM_MIN       = 30,
   parameter int BPM_MAX       = 300,
   parameter int BPM_DEFAULT   = 120,
   parameter int BEATS_PER_BAR = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_btn_reset,
   input  logic                  i_btn_plus_1,
   input  logic                  i_btn_plus_5,
   input  logic                  i_btn_minus_1,
   input  logic                  i_btn_minus_5,
   output logic [BPM_W-1:0]      o_bpm,
   output logic                  o_bpm_changed,
   output logic                  o_beat,
   output logic                  o_downbeat,
   output logic [BEAT_IDX_W-1:0] o_beat_idx
);

   localparam longint TICKS = longint'(60) * longint'(CLK_HZ);
   localparam int     ACC_W = $clog2(TICKS + longint'(BPM_MAX) + 1);

   localparam logic [BPM_W-1:0]   BPM_DEF_V = BPM_W'(BPM_DEFAULT);
   localparam logic signed [10:0] BPM_MIN_S = 11'(BPM_MIN);
   localparam logic signed [10:0] BPM_MAX_S = 11'(BPM_MAX);

   if (!params_ok(BPM_MIN, BPM_DEFAULT, BPM_MAX, BEATS_PER_BAR, TICKS)) begin : g_param_err
      $error("bpm_tempo_core: illegal tempo parameters");
   end

   function automatic logic [BPM_W-1:0] clamp_bpm(input logic signed [10:0] v);
      if (v < BPM_MIN_S)      return BPM_W'(BPM_MIN);
      else if (v > BPM_MAX_S) return BPM_W'(BPM_MAX);
      else                    return v[BPM_W-1:0];
   endfunction

   logic [BPM_W-1:0]   r_bpm;
   logic               r_changed;

   logic signed [10:0] w_delta;
   logic signed [10:0] w_bpm_sum;
   logic [BPM_W-1:0]   w_bpm_next;

   always_comb begin
      w_delta = '0;
      if (i_btn_plus_1)  w_delta = w_delta + DELTA_P1;
      if (i_btn_plus_5)  w_delta = w_delta + DELTA_P5;
      if (i_btn_minus_1) w_delta = w_delta + DELTA_M1;
      if (i_btn_minus_5) w_delta = w_delta + DELTA_M5;
   end

   assign w_bpm_sum  = $signed({2'b00, r_bpm}) + w_delta;
   assign w_bpm_next = clamp_bpm(w_bpm_sum);

   // Soft reset wins over any delta pulses arriving in the same cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bpm     <= BPM_DEF_V;
         r_changed <= 1'b0;
      end else if (i_btn_reset) begin
         r_bpm     <= BPM_DEF_V;
         r_changed <= (r_bpm != BPM_DEF_V);
      end else begin
         r_bpm     <= w_bpm_next;
         r_changed <= (w_bpm_next != r_bpm);
      end
   end

   beat_phase_acc #(
      .TICKS         (TICKS),
      .ACC_W         (ACC_W),
      .BPM_WIDTH     (BPM_W),
      .BEATS_PER_BAR (BEATS_PER_BAR)
   ) u_phase (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_bpm      (r_bpm),
      .i_clear    (i_btn_reset),
      .o_beat     (o_beat),
      .o_downbeat (o_downbeat),
      .o_idx      (o_beat_idx)
   );

   assign o_bpm         = r_bpm;
   assign o_bpm_changed = r_changed;

endmodule
